stream_downsizer: RTL and testbench



---
 rtl/stream_pkg.sv | 14 +
 rtl/stream_downsizer_if.sv | 33 +++
 rtl/stream_downsizer.sv | 53 +++++
 tb/tb_stream_downsizer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// stream_pkg: shared stream constants, index sizing helper and occupancy states
package stream_pkg;
  localparam int STREAM_MAX_RATIO = 16;
  localparam int STREAM_MIN_RATIO = 2;
  localparam int STREAM_DEF_RATIO = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  typedef logic [clog2(STREAM_DEF_RATIO)-1:0] beat_idx_t;
  typedef enum logic {EMPTY = 1'b0, SENDING = 1'b1} state_e;
endpackage

// File: rtl/stream_downsizer_if.sv
// stream_downsizer_if: wide-in / narrow-out handshake bundle; out_last exists only with STREAM_DOWNSIZER_LAST_EN
interface stream_downsizer_if
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 4
);
  localparam int IDX_W = clog2(RATIO);
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH*RATIO-1:0] in_data;
  logic [IDX_W-1:0]            in_beats;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH-1:0]       out_data;
`ifdef STREAM_DOWNSIZER_LAST_EN
  logic                        out_last;
`endif
  modport slave (
    input  in_valid, in_data, in_beats, out_ready,
    output in_ready, out_valid, out_data
`ifdef STREAM_DOWNSIZER_LAST_EN
    , output out_last
`endif
  );
  modport master (
    output in_valid, in_data, in_beats, out_ready,
    input  in_ready, out_valid, out_data
`ifdef STREAM_DOWNSIZER_LAST_EN
    , input out_last
`endif
  );
endinterface

// File: rtl/stream_downsizer.sv
// stream_downsizer: splits one wide word into in_beats+1 narrow beats; STREAM_DOWNSIZER_LAST_EN adds out_last
module stream_downsizer
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 4,
  parameter int MSB_FIRST  = 0
) (
  input logic              clk,
  input logic              rst_n,
  stream_downsizer_if.slave s
);
  localparam int IDX_W = clog2(RATIO);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(RATIO - 1);
  if (RATIO < STREAM_MIN_RATIO || RATIO > STREAM_MAX_RATIO) begin : g_ratio_check
    $error("stream_downsizer: RATIO out of range");
  end
  logic [DATA_WIDTH*RATIO-1:0] word_q, word_d;
  logic [IDX_W-1:0]            last_q, last_d, idx_q, idx_d, sel;
  state_e                      full_q, full_d;
  logic                        final_beat, accept, xfer;
  // handshake decode, slice select and next state; a load on the final beat wins over the drain
  always_comb begin
    final_beat  = (full_q == SENDING) && (idx_q == last_q);
    xfer        = (full_q == SENDING) && s.out_ready;
    s.in_ready  = rst_n && ((full_q == EMPTY) || (s.out_ready && final_beat));
    accept      = s.in_valid && s.in_ready;
    sel         = (MSB_FIRST != 0) ? MAX_IDX - idx_q : idx_q;
    s.out_valid = full_q == SENDING;
    s.out_data  = word_q[sel*DATA_WIDTH +: DATA_WIDTH];
    word_d      = accept ? s.in_data : word_q;
    last_d      = accept ? ((s.in_beats > MAX_IDX) ? MAX_IDX : s.in_beats) : last_q;
    idx_d       = accept ? '0 : (xfer && !final_beat) ? idx_q + IDX_W'(1) : xfer ? '0 : idx_q;
    full_d      = accept ? SENDING : (xfer && final_beat) ? EMPTY : full_q;
  end
`ifdef STREAM_DOWNSIZER_LAST_EN
  assign s.out_last = final_beat;
`endif
  // state registers; reset drops any partially sent word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      last_q <= '0;
      idx_q  <= '0;
      full_q <= EMPTY;
    end else begin
      word_q <= word_d;
      last_q <= last_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end
endmodule

// File: tb/tb_stream_downsizer.sv
// tb_stream_downsizer: directed checks of the downsizer (LSB-first x4, x3 clamp, MSB-first x4)
module tb_stream_downsizer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cnt;
  always #5 clk = ~clk;
  stream_downsizer_if #(.DATA_WIDTH(32), .RATIO(4)) a ();
  stream_downsizer_if #(.DATA_WIDTH(32), .RATIO(3)) b ();
  stream_downsizer_if #(.DATA_WIDTH(32), .RATIO(4)) m ();
  stream_downsizer #(.DATA_WIDTH(32), .RATIO(4), .MSB_FIRST(0)) u_dut (.clk(clk), .rst_n(rst_n), .s(a));
  stream_downsizer #(.DATA_WIDTH(32), .RATIO(3), .MSB_FIRST(0)) u_r3  (.clk(clk), .rst_n(rst_n), .s(b));
  stream_downsizer #(.DATA_WIDTH(32), .RATIO(4), .MSB_FIRST(1)) u_msb (.clk(clk), .rst_n(rst_n), .s(m));
  logic a_last, b_last, m_last;
`ifdef STREAM_DOWNSIZER_LAST_EN
  assign a_last = a.out_last;
  assign b_last = b.out_last;
  assign m_last = m.out_last;
`else
  assign a_last = 1'b0;
  assign b_last = 1'b0;
  assign m_last = 1'b0;
`endif
  localparam logic [127:0] W1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] W2 = 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa;
  logic [31:0] e1 [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [31:0] e2 [4] = '{32'haaaaaaaa, 32'hbbbbbbbb, 32'hcccccccc, 32'hdddddddd};
  logic [31:0] em [4] = '{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  logic [31:0] e3 [3] = '{32'haaaaaaaa, 32'hbbbbbbbb, 32'hcccccccc};
  logic        pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int          bidx [7] = '{0, 1, 1, 1, 2, 3, 3};
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic beat(input string tag, input logic v, input logic [31:0] d, input logic l,
                      input logic [31:0] ed, input logic el);
    check({tag, " valid"}, v, 1'b1);
    check({tag, " data"}, d, ed);
`ifdef STREAM_DOWNSIZER_LAST_EN
    check({tag, " last"}, l, el);
`endif
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk);
    a.in_valid = 0; a.in_data = '0; a.in_beats = '0; a.out_ready = 1;
    b.in_valid = 0; b.in_data = '0; b.in_beats = '0; b.out_ready = 1;
    m.in_valid = 0; m.in_data = '0; m.in_beats = '0; m.out_ready = 1;
    rst_n = 0;
    repeat (3) step();
    check("rst out_valid", a.out_valid, 1'b0);
    check("rst out_data", a.out_data, 32'h0);
    check("rst in_ready", a.in_ready, 1'b0);
    check("rst out_last", a_last, 1'b0);
    rst_n = 1;
    step();
    check("post-rst in_ready", a.in_ready, 1'b1);
    a.in_valid = 1; a.in_data = W1; a.in_beats = 2'd3;
    step();
    a.in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("full b%0d", i), a.out_valid, a.out_data, a_last, e1[i], i == 3);
      step();
    end
    check("full done valid", a.out_valid, 1'b0);
    a.in_valid = 1; a.in_data = W1; a.in_beats = 2'd3;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) a.in_data = W2;
      if (c == 5) a.in_valid = 0;
      check($sformatf("b2b c%0d valid", c), a.out_valid, c >= 1 && c <= 8);
      if (c >= 1 && c <= 4) check($sformatf("b2b c%0d data", c), a.out_data, e1[c-1]);
      if (c >= 5 && c <= 8) check($sformatf("b2b c%0d data", c), a.out_data, e2[c-5]);
      check($sformatf("b2b c%0d in_ready", c), a.in_ready, c == 0 || c == 4 || c == 8 || c == 9);
      step();
    end
    a.in_valid = 1; a.in_data = W2; a.in_beats = 2'd1;
    step();
    a.in_valid = 0;
    beat("part b0", a.out_valid, a.out_data, a_last, e2[0], 1'b0);
    step();
    beat("part b1", a.out_valid, a.out_data, a_last, e2[1], 1'b1);
    step();
    check("part done valid", a.out_valid, 1'b0);
    b.in_valid = 1; b.in_data = 96'hcccccccc_bbbbbbbb_aaaaaaaa; b.in_beats = 2'd3;
    step();
    b.in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("clamp b%0d", i), b.out_valid, b.out_data, b_last, e3[i], i == 2);
      step();
    end
    check("clamp done valid", b.out_valid, 1'b0);
    a.in_valid = 1; a.in_data = W1; a.in_beats = 2'd3;
    step();
    a.in_valid = 0;
    cnt = 0;
    for (int c = 0; c < 7; c++) begin
      a.out_ready = pat[c];
      beat($sformatf("bp c%0d", c), a.out_valid, a.out_data, a_last, e1[bidx[c]], bidx[c] == 3);
      if (a.out_valid && a.out_ready) cnt++;
      step();
    end
    a.out_ready = 1;
    check("bp done valid", a.out_valid, 1'b0);
    check("bp delivered", 128'(cnt), 128'd4);
    m.in_valid = 1; m.in_data = W1; m.in_beats = 2'd3;
    step();
    m.in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("msb b%0d", i), m.out_valid, m.out_data, m_last, em[i], i == 3);
      step();
    end
    check("msb done valid", m.out_valid, 1'b0);
    a.in_valid = 1; a.in_data = W2; a.in_beats = 2'd3;
    step();
    a.in_valid = 0;
    beat("mid b0", a.out_valid, a.out_data, a_last, e2[0], 1'b0);
    step();
    beat("mid b1", a.out_valid, a.out_data, a_last, e2[1], 1'b0);
    rst_n = 0;
    #1;
    check("mid rst in_ready comb", a.in_ready, 1'b0);
    step();
    check("mid rst out_valid", a.out_valid, 1'b0);
    check("mid rst out_data", a.out_data, 32'h0);
    check("mid rst in_ready", a.in_ready, 1'b0);
    rst_n = 1;
    a.in_valid = 1; a.in_data = W1; a.in_beats = 2'd3;
    step();
    a.in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("restart b%0d", i), a.out_valid, a.out_data, a_last, e1[i], i == 3);
      step();
    end
    check("restart done valid", a.out_valid, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
